// File: rtl/elevator_call_scheduler.sv
// Elevator call scheduler: latches floor calls, sweeps the car in one
// direction while requests remain ahead, then holds the door for DWELL cycles.
module elevator_call_scheduler #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] call_btn,
  input  logic [2:0] cur_floor,
  output logic [2:0] target_floor,
  output logic [7:0] pending,
  output logic       door_open,
  output logic       dir_up,
  output logic       served
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] MOVE_UP   = 2'd1;
  localparam logic [1:0] MOVE_DOWN = 2'd2;
  localparam logic [1:0] DOOR      = 2'd3;

  logic [1:0] state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [2:0] target_q, target_d;
  logic [3:0] cnt_q, cnt_d;
  logic       dir_q, dir_d;
  logic       door_q, door_d;
  logic       served_q, served_d;

  logic [7:0] mask_above, mask_below;
  logic       up_any, dn_any, here, clr;

  // Nearest pending floor strictly above f (f itself if none).
  function automatic logic [2:0] low_above(input logic [7:0] p, input logic [2:0] f);
    logic [2:0] r;
    r = f;
    for (int i = 7; i >= 0; i--)
      if (p[i] && (3'(i) > f)) r = 3'(i);
    return r;
  endfunction

  // Nearest pending floor strictly below f (f itself if none).
  function automatic logic [2:0] high_below(input logic [7:0] p, input logic [2:0] f);
    logic [2:0] r;
    r = f;
    for (int i = 0; i < 8; i++)
      if (p[i] && (3'(i) < f)) r = 3'(i);
    return r;
  endfunction

  // Next-state, request bookkeeping and registered output values.
  always_comb begin
    mask_above = 8'hFE << cur_floor;
    mask_below = ~(8'hFF << cur_floor);
    up_any     = |(pending_q & mask_above);
    dn_any     = |(pending_q & mask_below);
    here       = pending_q[cur_floor];

    state_d   = state_q;
    pending_d = pending_q | call_btn;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    served_d  = 1'b0;
    clr       = 1'b0;

    case (state_q)
      IDLE: begin
        if (here) clr = 1'b1;
        else if (up_any) begin
          state_d = MOVE_UP;
          dir_d   = 1'b1;
        end else if (dn_any) begin
          state_d = MOVE_DOWN;
          dir_d   = 1'b0;
        end
      end
      MOVE_UP: begin
        if (here) clr = 1'b1;
        else if (!up_any) state_d = IDLE;
      end
      MOVE_DOWN: begin
        if (here) clr = 1'b1;
        else if (!dn_any) state_d = IDLE;
      end
      default: begin
        // A press at the open floor only extends the dwell; it is not a new call.
        pending_d[cur_floor] = pending_q[cur_floor];
        if (call_btn[cur_floor]) cnt_d = 4'(DWELL);
        else if (cnt_q > 4'd1) cnt_d = cnt_q - 4'd1;
        else begin
          cnt_d = 4'd0;
          if (dir_q ? up_any : dn_any)
            state_d = dir_q ? MOVE_UP : MOVE_DOWN;
          else if (dir_q ? dn_any : up_any) begin
            state_d = dir_q ? MOVE_DOWN : MOVE_UP;
            dir_d   = ~dir_q;
          end else state_d = IDLE;
        end
      end
    endcase

    // Serving a floor overrides any same-cycle press of that floor's button.
    if (clr) begin
      pending_d[cur_floor] = 1'b0;
      served_d             = 1'b1;
      cnt_d                = 4'(DWELL);
      state_d              = DOOR;
    end

    case (state_d)
      MOVE_UP:   target_d = low_above(pending_d, cur_floor);
      MOVE_DOWN: target_d = high_below(pending_d, cur_floor);
      default:   target_d = cur_floor;
    endcase
    door_d = (state_d == DOOR);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pending_q <= 8'h00;
      target_q  <= 3'd0;
      cnt_q     <= 4'd0;
      dir_q     <= 1'b1;
      door_q    <= 1'b0;
      served_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      door_q    <= door_d;
      served_q  <= served_d;
    end
  end

  assign target_floor = target_q;
  assign pending      = pending_q;
  assign door_open    = door_q;
  assign dir_up       = dir_q;
  assign served       = served_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler (DWELL = 4).
module tb_elevator_call_scheduler;
  logic       clk, rst;
  logic [7:0] call_btn;
  logic [2:0] cur_floor;
  logic [2:0] target_floor;
  logic [7:0] pending;
  logic       door_open, dir_up, served;

  int checks = 0;
  int errors = 0;

  elevator_call_scheduler #(.DWELL(4)) dut (
    .clk(clk), .rst(rst), .call_btn(call_btn), .cur_floor(cur_floor),
    .target_floor(target_floor), .pending(pending), .door_open(door_open),
    .dir_up(dir_up), .served(served)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; call_btn = 8'h00; cur_floor = 3'd0;
    repeat (2) tick();
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL rst_pending: got %h exp 00", pending); end
    checks++; if (target_floor !== 3'd0) begin errors++; $display("FAIL rst_target: got %0d exp 0", target_floor); end
    checks++; if (door_open !== 1'b0 || served !== 1'b0) begin errors++; $display("FAIL rst_door_served: got %b%b exp 00", door_open, served); end
    checks++; if (dir_up !== 1'b1) begin errors++; $display("FAIL rst_dir: got %b exp 1", dir_up); end
    rst = 1'b1;
    tick();
    checks++; if (pending !== 8'h00 || door_open !== 1'b0) begin errors++; $display("FAIL rst_idle: got %h/%b exp 00/0", pending, door_open); end
  endtask

  task automatic test_basic();
    call_btn = 8'h20;
    tick();
    checks++; if (pending !== 8'h20) begin errors++; $display("FAIL basic_latch: got %h exp 20", pending); end
    checks++; if (target_floor !== 3'd0) begin errors++; $display("FAIL basic_idle_target: got %0d exp 0", target_floor); end
    call_btn = 8'h00;
    tick();
    checks++; if (target_floor !== 3'd5 || dir_up !== 1'b1) begin errors++; $display("FAIL basic_move: got t=%0d d=%b exp t=5 d=1", target_floor, dir_up); end
    for (int f = 1; f <= 4; f++) begin
      cur_floor = 3'(f);
      tick();
      checks++; if (target_floor !== 3'd5 || served !== 1'b0) begin errors++; $display("FAIL basic_travel: got t=%0d s=%b exp t=5 s=0", target_floor, served); end
    end
    cur_floor = 3'd5;
    tick();
    checks++; if (served !== 1'b1 || pending !== 8'h00 || door_open !== 1'b1) begin errors++; $display("FAIL basic_arrive: got s=%b p=%h d=%b exp 1/00/1", served, pending, door_open); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (door_open !== 1'b1 || served !== 1'b0) begin errors++; $display("FAIL basic_dwell: got d=%b s=%b exp 1/0", door_open, served); end
    end
    tick();
    checks++; if (door_open !== 1'b0 || target_floor !== 3'd5) begin errors++; $display("FAIL basic_idle: got d=%b t=%0d exp 0/5", door_open, target_floor); end
  endtask

  task automatic test_pickup();
    cur_floor = 3'd2; call_btn = 8'h40;
    tick();
    checks++; if (pending !== 8'h40 || target_floor !== 3'd2) begin errors++; $display("FAIL pick_latch: got p=%h t=%0d exp 40/2", pending, target_floor); end
    call_btn = 8'h00;
    tick();
    checks++; if (target_floor !== 3'd6) begin errors++; $display("FAIL pick_go6: got %0d exp 6", target_floor); end
    cur_floor = 3'd3; call_btn = 8'h10;
    tick();
    checks++; if (target_floor !== 3'd4 || pending !== 8'h50) begin errors++; $display("FAIL pick_retarget: got t=%0d p=%h exp 4/50", target_floor, pending); end
    call_btn = 8'h00; cur_floor = 3'd4;
    tick();
    checks++; if (served !== 1'b1 || pending !== 8'h40 || door_open !== 1'b1) begin errors++; $display("FAIL pick_stop4: got s=%b p=%h d=%b exp 1/40/1", served, pending, door_open); end
    repeat (3) tick();
    tick();
    checks++; if (door_open !== 1'b0 || target_floor !== 3'd6 || dir_up !== 1'b1) begin errors++; $display("FAIL pick_resume: got d=%b t=%0d u=%b exp 0/6/1", door_open, target_floor, dir_up); end
    cur_floor = 3'd5; tick();
    cur_floor = 3'd6; tick();
    checks++; if (served !== 1'b1 || pending !== 8'h00) begin errors++; $display("FAIL pick_stop6: got s=%b p=%h exp 1/00", served, pending); end
    repeat (4) tick();
    checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL pick_idle: got %b exp 0", door_open); end
  endtask

  task automatic test_reverse();
    cur_floor = 3'd3; call_btn = 8'h42;
    tick();
    checks++; if (pending !== 8'h42) begin errors++; $display("FAIL rev_latch: got %h exp 42", pending); end
    call_btn = 8'h00;
    tick();
    checks++; if (target_floor !== 3'd6 || dir_up !== 1'b1) begin errors++; $display("FAIL rev_up_first: got t=%0d u=%b exp 6/1", target_floor, dir_up); end
    cur_floor = 3'd4; tick();
    cur_floor = 3'd5; tick();
    cur_floor = 3'd6; tick();
    checks++; if (served !== 1'b1 || pending !== 8'h02) begin errors++; $display("FAIL rev_stop6: got s=%b p=%h exp 1/02", served, pending); end
    repeat (3) tick();
    tick();
    checks++; if (dir_up !== 1'b0 || target_floor !== 3'd1 || door_open !== 1'b0) begin errors++; $display("FAIL rev_turn: got u=%b t=%0d d=%b exp 0/1/0", dir_up, target_floor, door_open); end
    for (int f = 5; f >= 1; f--) begin
      cur_floor = 3'(f);
      tick();
    end
    checks++; if (served !== 1'b1 || pending !== 8'h00) begin errors++; $display("FAIL rev_stop1: got s=%b p=%h exp 1/00", served, pending); end
    repeat (4) tick();
    checks++; if (door_open !== 1'b0 || dir_up !== 1'b0) begin errors++; $display("FAIL rev_idle: got d=%b u=%b exp 0/0", door_open, dir_up); end
  endtask

  task automatic test_door_hold();
    cur_floor = 3'd2; call_btn = 8'h04;
    tick();
    call_btn = 8'h00;
    tick();
    checks++; if (served !== 1'b1 || door_open !== 1'b1 || pending !== 8'h00) begin errors++; $display("FAIL hold_open: got s=%b d=%b p=%h exp 1/1/00", served, door_open, pending); end
    call_btn = 8'h04;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (door_open !== 1'b1 || served !== 1'b0 || pending[2] !== 1'b0) begin errors++; $display("FAIL hold_btn: got d=%b s=%b p2=%b exp 1/0/0", door_open, served, pending[2]); end
    end
    call_btn = 8'h00;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (door_open !== 1'b1 || served !== 1'b0) begin errors++; $display("FAIL hold_after: got d=%b s=%b exp 1/0", door_open, served); end
    end
    tick();
    checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL hold_close: got %b exp 0", door_open); end
    tick();
    checks++; if (served !== 1'b0 || door_open !== 1'b0 || pending !== 8'h00) begin errors++; $display("FAIL hold_idle: got s=%b d=%b p=%h exp 0/0/00", served, door_open, pending); end
  endtask

  task automatic test_reset_mid();
    cur_floor = 3'd4; call_btn = 8'h0B;
    tick();
    call_btn = 8'h00;
    tick();
    checks++; if (dir_up !== 1'b0 || target_floor !== 3'd3 || pending !== 8'h0B) begin errors++; $display("FAIL rmid_down: got u=%b t=%0d p=%h exp 0/3/0b", dir_up, target_floor, pending); end
    #2 rst = 1'b0;
    #1;
    checks++; if (pending !== 8'h00 || target_floor !== 3'd0) begin errors++; $display("FAIL rmid_async: got p=%h t=%0d exp 00/0", pending, target_floor); end
    checks++; if (door_open !== 1'b0 || dir_up !== 1'b1 || served !== 1'b0) begin errors++; $display("FAIL rmid_flags: got d=%b u=%b s=%b exp 0/1/0", door_open, dir_up, served); end
    call_btn = 8'h40;
    tick();
    rst = 1'b1;
    tick();
    checks++; if (pending !== 8'h40 || target_floor !== 3'd4) begin errors++; $display("FAIL rmid_latch: got p=%h t=%0d exp 40/4", pending, target_floor); end
    tick();
    checks++; if (target_floor !== 3'd6 || dir_up !== 1'b1) begin errors++; $display("FAIL rmid_decide: got t=%0d u=%b exp 6/1", target_floor, dir_up); end
    call_btn = 8'h00;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pickup();
    test_reverse();
    test_door_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
